// File: rtl/ltm_serial_arbiter_if.sv
// Shared LTM serial pin arbitration bus: the two serial controllers' requests
// and pin sources on one side, grants and shared pin drivers on the other.
interface ltm_serial_arbiter_if;
  logic       LCD_req_i;
  logic       LCD_sclk_i;
  logic       LCD_grant_o;
  logic       TP_req_i;
  logic       TP_sclk_i;
  logic       TP_ss_n_i;
  logic       TP_window_i;
  logic       TP_grant_o;
  logic       Shared_sclk_o;
  logic       Shared_scen_o;
  logic [1:0] Owner_o;
  logic       Timeout_o;

  // Controllers / pin consumers side
  modport master (
    output LCD_req_i, LCD_sclk_i, TP_req_i, TP_sclk_i, TP_ss_n_i, TP_window_i,
    input  LCD_grant_o, TP_grant_o, Shared_sclk_o, Shared_scen_o, Owner_o, Timeout_o
  );

  // Arbiter side
  modport slave (
    input  LCD_req_i, LCD_sclk_i, TP_req_i, TP_sclk_i, TP_ss_n_i, TP_window_i,
    output LCD_grant_o, TP_grant_o, Shared_sclk_o, Shared_scen_o, Owner_o, Timeout_o
  );
endinterface

// File: rtl/ltm_serial_arbiter.sv
// Arbiter for the LTM shared SCLK/SCEN pins between the LCD config controller
// and the touch-panel controller: round-robin grant, guard gap between owners,
// hold watchdog with per-requester lockout, registered pin mux.
module ltm_serial_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic        IDLE_SCLK      = 1'b1
) (
  input logic                 Clock,
  input logic                 Reset,
  ltm_serial_arbiter_if.slave bus
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [23:0]   WD_LAST    = 24'(TIMEOUT_CYCLES - 1);
  localparam logic          WD_EN      = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, GRANT_LCD, GRANT_TP, GUARD} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [23:0]   wd_q, wd_d;
  logic          rr_q, rr_d;            // 1: TP wins the next tie
  logic          lock_lcd_q, lock_lcd_d;
  logic          lock_tp_q, lock_tp_d;
  logic          timeout_q, timeout_d;
  logic          sclk_q, sclk_d;
  logic          scen_q, scen_d;

  logic elig_lcd, elig_tp, wd_exp;

  assign elig_lcd = bus.LCD_req_i & ~lock_lcd_q;
  // Window only gates new grants; an active TP grant ignores it.
  assign elig_tp  = bus.TP_req_i & bus.TP_window_i & ~lock_tp_q;
  // wd_q counts grant cycles already completed before this edge, so at
  // wd_q == T-1 the grant has been high for T cycles.
  assign wd_exp   = WD_EN && (wd_q == WD_LAST);

  // Next-state, arbitration, watchdog and lockout bookkeeping
  always_comb begin
    state_d    = state_q;
    gcnt_d     = gcnt_q;
    wd_d       = wd_q;
    rr_d       = rr_q;
    timeout_d  = 1'b0;
    // A lockout clears once its request is seen low.
    lock_lcd_d = lock_lcd_q & bus.LCD_req_i;
    lock_tp_d  = lock_tp_q & bus.TP_req_i;
    case (state_q)
      IDLE: begin
        if (elig_lcd && (!elig_tp || !rr_q)) begin
          state_d = GRANT_LCD;
          rr_d    = 1'b1;
          wd_d    = '0;
        end else if (elig_tp) begin
          state_d = GRANT_TP;
          rr_d    = 1'b0;
          wd_d    = '0;
        end
      end
      GRANT_LCD: begin
        // A drop on the expiry edge is a normal release.
        if (!bus.LCD_req_i) begin
          state_d = GUARD;
          gcnt_d  = '0;
        end else if (wd_exp) begin
          state_d    = GUARD;
          gcnt_d     = '0;
          timeout_d  = 1'b1;
          lock_lcd_d = 1'b1;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 24'd1;
        end
      end
      GRANT_TP: begin
        if (!bus.TP_req_i) begin
          state_d = GUARD;
          gcnt_d  = '0;
        end else if (wd_exp) begin
          state_d   = GUARD;
          gcnt_d    = '0;
          timeout_d = 1'b1;
          lock_tp_d = 1'b1;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 24'd1;
        end
      end
      GUARD: begin
        if (gcnt_q == GUARD_LAST) state_d = IDLE;
        else                      gcnt_d  = gcnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin mux keyed on the next owner so pins switch on the grant edge
  always_comb begin
    sclk_d = IDLE_SCLK;
    scen_d = 1'b1;
    case (state_d)
      GRANT_LCD: begin
        sclk_d = bus.LCD_sclk_i;
        scen_d = 1'b0;
      end
      GRANT_TP: begin
        sclk_d = bus.TP_sclk_i;
        scen_d = ~bus.TP_ss_n_i;
      end
      default: ;
    endcase
  end

  // State and pin registers, async reset to idle pins / LCD-favoured pointer
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      gcnt_q     <= '0;
      wd_q       <= '0;
      rr_q       <= 1'b0;
      lock_lcd_q <= 1'b0;
      lock_tp_q  <= 1'b0;
      timeout_q  <= 1'b0;
      sclk_q     <= IDLE_SCLK;
      scen_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      gcnt_q     <= gcnt_d;
      wd_q       <= wd_d;
      rr_q       <= rr_d;
      lock_lcd_q <= lock_lcd_d;
      lock_tp_q  <= lock_tp_d;
      timeout_q  <= timeout_d;
      sclk_q     <= sclk_d;
      scen_q     <= scen_d;
    end
  end

  assign bus.LCD_grant_o   = (state_q == GRANT_LCD);
  assign bus.TP_grant_o    = (state_q == GRANT_TP);
  assign bus.Owner_o       = {state_q == GRANT_TP, state_q == GRANT_LCD};
  assign bus.Timeout_o     = timeout_q;
  assign bus.Shared_sclk_o = sclk_q;
  assign bus.Shared_scen_o = scen_q;

endmodule

// File: tb/tb_ltm_serial_arbiter.sv
// Bench for ltm_serial_arbiter: directed scenarios plus random request traffic,
// expected pin/grant state per cycle queued by a reference model, compared by
// an independent monitor on the falling edge.
module tb_ltm_serial_arbiter;
  localparam int   G    = 4;
  localparam int   T    = 16;
  localparam logic IDLE = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ltm_serial_arbiter_if bus();

  ltm_serial_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T), .IDLE_SCLK(IDLE)) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic       lg;
    logic       tg;
    logic [1:0] owner;
    logic       to;
    logic       sclk;
    logic       scen;
  } obs_t;

  obs_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  // Reference model: owner 0 none / 1 LCD / 2 TP
  int m_owner, m_guard, m_held;
  bit m_lock_l, m_lock_t, m_last_lcd;

  function automatic obs_t reset_obs();
    obs_t o;
    o = '{lg: 1'b0, tg: 1'b0, owner: 2'b00, to: 1'b0, sclk: IDLE, scen: 1'b1};
    return o;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_guard = 0; m_held = 0;
    m_lock_l = 0; m_lock_t = 0; m_last_lcd = 0;
  endtask

  task automatic model_step();
    obs_t o;
    bit lr, tr, r, to, el, et;
    lr = bus.LCD_req_i;
    tr = bus.TP_req_i;
    to = 0;
    if (!lr) m_lock_l = 0;
    if (!tr) m_lock_t = 0;
    if (m_owner != 0) begin
      r = (m_owner == 1) ? lr : tr;
      m_held++;
      if (!r) begin
        m_owner = 0; m_guard = G;
      end else if (T != 0 && m_held >= T) begin
        to = 1;
        if (m_owner == 1) m_lock_l = 1; else m_lock_t = 1;
        m_owner = 0; m_guard = G;
      end
    end else if (m_guard > 0) begin
      m_guard--;
    end else begin
      el = lr && !m_lock_l;
      et = tr && bus.TP_window_i && !m_lock_t;
      if (el && et)  m_owner = m_last_lcd ? 2 : 1;
      else if (el)   m_owner = 1;
      else if (et)   m_owner = 2;
      if (m_owner != 0) begin
        m_held = 0;
        m_last_lcd = (m_owner == 1);
      end
    end
    o.lg    = (m_owner == 1);
    o.tg    = (m_owner == 2);
    o.owner = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    o.to    = to;
    o.sclk  = (m_owner == 1) ? bus.LCD_sclk_i : (m_owner == 2) ? bus.TP_sclk_i : IDLE;
    o.scen  = (m_owner == 1) ? 1'b0 : (m_owner == 2) ? ~bus.TP_ss_n_i : 1'b1;
    sb.push_back(o);
  endtask

  // Stimulus side of the scoreboard: predict on every active edge
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
      sb.push_back(reset_obs());
    end else begin
      model_step();
    end
  end

  // Monitor: DUT presents a full pin/grant state every cycle
  always @(negedge clk) begin
    obs_t e, a;
    if (!done) begin
      checks++;
      a = '{lg: bus.LCD_grant_o, tg: bus.TP_grant_o, owner: bus.Owner_o,
            to: bus.Timeout_o, sclk: bus.Shared_sclk_o, scen: bus.Shared_scen_o};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got=%b", $time, a);
      end else begin
        e = sb.pop_front();
        if (a !== e)  begin
          errors++;
          $display("FAIL outputs t=%0t got{lg,tg,own,to,sclk,scen}=%b want=%b", $time, a, e);
        end
      end
    end
  end

  // Advance n cycles, randomizing pin sources; returns 2 time units after an edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      bus.LCD_sclk_i = 1'($urandom);
      bus.TP_sclk_i  = 1'($urandom);
      bus.TP_ss_n_i  = 1'($urandom);
    end
  endtask

  // Async reset asserted between edges, held across one edge
  task automatic mid_reset();
    #1;
    rst = 1'b1;
    sb.delete();
    model_reset();
    sb.push_back(reset_obs());
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    bus.LCD_req_i = 0; bus.LCD_sclk_i = 0;
    bus.TP_req_i = 0;  bus.TP_sclk_i = 0; bus.TP_ss_n_i = 1; bus.TP_window_i = 0;
    cyc(2);
    rst = 1'b0;
    cyc(3);

    // LCD only, then guard gap
    bus.LCD_req_i = 1; cyc(10);
    bus.LCD_req_i = 0; cyc(10);

    // Both requesting out of reset: LCD first, then TP, next tie to LCD
    bus.LCD_req_i = 1; bus.TP_req_i = 1; bus.TP_window_i = 1;
    mid_reset();
    cyc(8);
    bus.LCD_req_i = 0; cyc(12);
    bus.LCD_req_i = 1; cyc(3);
    bus.TP_req_i = 0;  cyc(10);
    bus.LCD_req_i = 0; cyc(8);

    // Window gating; window falling mid-grant keeps the grant
    bus.TP_window_i = 0; bus.TP_req_i = 1; cyc(50);
    bus.TP_window_i = 1; cyc(3);
    bus.TP_window_i = 0; cyc(6);
    bus.TP_req_i = 0;    cyc(8);

    // Watchdog on TP, lockout until req seen low
    bus.TP_window_i = 1; bus.TP_req_i = 1; cyc(40);
    bus.TP_req_i = 0; cyc(1);
    bus.TP_req_i = 1; cyc(8);
    bus.TP_req_i = 0; cyc(8);

    // Watchdog on LCD with TP waiting
    bus.LCD_req_i = 1; cyc(2);
    bus.TP_req_i = 1;  cyc(30);
    bus.TP_req_i = 0;  bus.LCD_req_i = 0; cyc(8);

    // Reset mid TP grant, then both request: LCD wins
    bus.TP_req_i = 1; cyc(10);
    mid_reset();
    bus.TP_req_i = 0; cyc(2);
    bus.LCD_req_i = 1; bus.TP_req_i = 1; cyc(6);
    bus.LCD_req_i = 0; bus.TP_req_i = 0; cyc(8);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  bus.LCD_req_i   = ~bus.LCD_req_i;
      if ($urandom_range(0, 7) == 0)  bus.TP_req_i    = ~bus.TP_req_i;
      if ($urandom_range(0, 11) == 0) bus.TP_window_i = ~bus.TP_window_i;
      if ($urandom_range(0, 999) == 0) mid_reset();
      cyc(1);
    end

    bus.LCD_req_i = 0; bus.TP_req_i = 0;
    cyc(3);
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
